// File: rtl/cordic_iter_seq.sv
// Iteration sequencer for a CORDIC datapath: issues shift indices 0..N_ITER-1, with optional repeats.
// Define CORDIC_SEQ_REPEAT_EN to enable the per-index repeat of shift indices 0..5.
module cordic_iter_seq #(
   parameter int N_ITER = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] sel,
   output logic [3:0] sel_out,
   input  logic       r0,
   input  logic       r1,
   input  logic       r2,
   input  logic       r3,
   input  logic       r4,
   input  logic       r5,
   output logic       load,
   output logic       iter_en,
   output logic [3:0] iter_idx,
   output logic       rep,
   output logic       busy,
   output logic       done,
   output logic [4:0] step_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ITER,
      S_REPEAT,
      S_DONE
   } state_t;

   localparam logic [3:0] LAST_IDX = 4'(N_ITER - 1);

`ifdef CORDIC_SEQ_REPEAT_EN
   localparam logic [5:0] REP_ALLOW = 6'h3F;
`else
   localparam logic [5:0] REP_ALLOW = 6'h00;
`endif

   state_t     state;
   state_t     state_nx;
   logic [5:0] mask;
   logic [7:0] mask_ext;
   logic [3:0] idx;
   logic       rep_hit;
   logic       at_last;

   // Only indices 0..5 can repeat; the two padding bits keep the select in range.
   assign mask_ext = {2'b00, mask};
   assign rep_hit  = (idx <= 4'd5) && mask_ext[idx[2:0]];
   assign at_last  = (idx == LAST_IDX);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (start) state_nx = S_LOAD;
         S_LOAD:   state_nx = S_ITER;
         S_ITER: begin
            if (rep_hit)      state_nx = S_REPEAT;
            else if (at_last) state_nx = S_DONE;
            else              state_nx = S_ITER;
         end
         S_REPEAT: state_nx = at_last ? S_DONE : S_ITER;
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         sel_out  <= '0;
         mask     <= '0;
         idx      <= '0;
         step_cnt <= '0;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: begin
               if (start) begin
                  sel_out  <= sel;
                  step_cnt <= '0;
               end
            end
            S_LOAD: begin
               mask <= {r5, r4, r3, r2, r1, r0} & REP_ALLOW;
               idx  <= '0;
            end
            S_ITER: begin
               step_cnt <= step_cnt + 5'd1;
               if (!rep_hit && !at_last) idx <= idx + 4'd1;
            end
            S_REPEAT: begin
               step_cnt <= step_cnt + 5'd1;
               if (!at_last) idx <= idx + 4'd1;
            end
            default: ;
         endcase
      end
   end

   // Strobes are pure state decodes, so reset clears them at once.
   assign load     = (state == S_LOAD);
   assign iter_en  = (state == S_ITER) || (state == S_REPEAT);
   assign rep      = (state == S_REPEAT);
   assign busy     = (state == S_LOAD) || (state == S_ITER) || (state == S_REPEAT);
   assign done     = (state == S_DONE);
   assign iter_idx = idx;

endmodule

// File: doc/cordic_iter_seq.md
CORDIC_ITER_SEQ -- requirements
Module: cordic_iter_seq

Interface
REQ-001 The block SHALL have parameter N_ITER, default 16, meaning the number of distinct CORDIC iterations (shift indices 0..N_ITER-1); legal range 6..16.
REQ-002 The block SHALL have port clk  input  1  the single rising-edge clock.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port start  input  1  request to begin one rotation; sampled only in IDLE.
REQ-005 The block SHALL have port sel  input  4  repeat-selection code, latched on an accepted start.
REQ-006 The block SHALL have port sel_out  output  4  latched code driven to the ip input of rep_iter_selection.
REQ-007 The block SHALL have ports r0..r5  input  1 each  repeat flags returned by rep_iter_selection for shift indices 0..5.
REQ-008 The block SHALL have port load  output  1  one-cycle datapath initial-value load strobe.
REQ-009 The block SHALL have port iter_en  output  1  datapath micro-rotation enable.
REQ-010 The block SHALL have port iter_idx  output  4  shift index for the current micro-rotation.
REQ-011 The block SHALL have port rep  output  1  high when the current micro-rotation is a repeat.
REQ-012 The block SHALL have port busy  output  1  high in LOAD, ITER and REPEAT.
REQ-013 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 The block SHALL have port step_cnt  output  5  micro-rotations executed in the current/last rotation.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, ITER, REPEAT, DONE; all outputs are registered or decoded from state.
REQ-016 In IDLE with start=1, the block SHALL latch sel into sel_out, clear step_cnt, and enter LOAD next cycle; start=0 keeps IDLE.
REQ-017 In LOAD, load SHALL be 1 for exactly one cycle, r0..r5 SHALL be registered into an internal rep mask, idx SHALL be set to 0, and the next state is ITER.
REQ-018 In ITER, iter_en=1, rep=0 and iter_idx=idx; step_cnt increments by 1 each ITER or REPEAT cycle.
REQ-019 From ITER, if idx<=5 and rep mask bit idx=1 the next state SHALL be REPEAT with idx unchanged; else if idx=N_ITER-1 the next state is DONE; else ITER with idx+1.
REQ-020 In REPEAT, iter_en=1, rep=1, iter_idx=idx; the next state SHALL be DONE if idx=N_ITER-1, else ITER with idx+1; an index is repeated at most once.
REQ-021 In DONE, done=1 for one cycle, busy=0, then IDLE; step_cnt holds its final value until the next accepted start.
REQ-022 Latency: done SHALL assert exactly N_ITER+2+k cycles after the start-sampling edge, k = number of set mask bits with index < N_ITER.
REQ-023 start SHALL be ignored in LOAD, ITER, REPEAT and DONE; start in the first IDLE cycle after DONE is accepted.
REQ-024 Changes on sel or r0..r5 after the LOAD cycle SHALL not affect the running rotation.
REQ-025 In every state other than the named one, load, iter_en, rep and done SHALL be 0.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, sel_out=0, mask=0, idx=0, iter_idx=0, step_cnt=0, and load, iter_en, rep, busy, done all 0, independent of clk.
REQ-027 Reset asserted mid-rotation SHALL abort it without a done pulse; after release the block waits in IDLE for start.

Configuration
REQ-028 With macro CORDIC_SEQ_REPEAT_EN defined, repeats SHALL follow REQ-019/020.
REQ-029 Without CORDIC_SEQ_REPEAT_EN, the rep mask SHALL be forced to 0, REPEAT is unreachable, rep stays 0, and latency is always N_ITER+2.

Verification
REQ-030 N_ITER=16, macro defined, start with sel=4'h3, r0..r5=0 -> load at cycle 1, iter_idx 0..15 cycles 2..17, done at cycle 18, step_cnt=16.
REQ-031 Macro defined, r1=r4=1 -> iter_idx sequence 0,1,1,2,3,4,4,5..15 with rep=1 on the second 1 and second 4, done at cycle 20, step_cnt=18.
REQ-032 Macro defined, r0..r5 all 1 -> each of indices 0..5 issued twice, done at cycle 24, step_cnt=22.
REQ-033 start held high continuously from cycle 0 -> second load occurs in the cycle after the first done's IDLE cycle, no start accepted while busy.
REQ-034 rst_n pulsed low at cycle 9 of a rotation -> all outputs 0 asynchronously, no done, next start produces a full normal rotation.
REQ-035 Macro undefined, r0..r5 all 1 -> no rep pulses, done at cycle 18, step_cnt=16.
